chip_sched: RTL and testbench

Frame scheduler for the chip path. Shares the single chip output channel among eight sensor-module channels. Grants one channel at a time, round-robin. Holds each frame start until the downstream chip buffer reports ready, then gates exactly `cfg_len` sample strobes through as one frame. Sits between the sensor-module data strobes and the chip path mux, driving its path select and valid gating.

---
 rtl/chip_sched_if.sv | 45 ++++
 rtl/chip_sched.sv | 175 +++++++++++++++++
 tb/tb_chip_sched.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chip_sched_if.sv
// chip_sched_if
//   Groups the scheduler's request/config inputs and its frame-gating outputs
//   into one bundle, so the channel side and the scheduler share one port.
//
//   master : the side that raises requests, supplies config, sample strobes
//            and buffer ready, and watches the grant/frame outputs.
//   slave  : the scheduler itself (chip_sched).
//
//   Signals:
//     req[7:0]       per-channel frame request (level)
//     cfg_mask[7:0]  channel enable
//     cfg_len[19:0]  frame length in samples
//     sm_vld         common sample strobe
//     buf_rdy        chip buffer can accept a full frame
//     grant[7:0]     one-hot granted channel
//     sel_path[6:0]  {seq[3:0], ch[2:0]}
//     frm_vld        gated sample strobe
//     frm_cnt[19:0]  samples passed in the current frame
//     frm_done       end-of-frame pulse
//     to_err         ready-wait timeout pulse
//     busy           scheduler not idle
interface chip_sched_if;
  logic [7:0]  req;
  logic [7:0]  cfg_mask;
  logic [19:0] cfg_len;
  logic        sm_vld;
  logic        buf_rdy;
  logic [7:0]  grant;
  logic [6:0]  sel_path;
  logic        frm_vld;
  logic [19:0] frm_cnt;
  logic        frm_done;
  logic        to_err;
  logic        busy;

  modport master (
    output req, cfg_mask, cfg_len, sm_vld, buf_rdy,
    input  grant, sel_path, frm_vld, frm_cnt, frm_done, to_err, busy
  );

  modport slave (
    input  req, cfg_mask, cfg_len, sm_vld, buf_rdy,
    output grant, sel_path, frm_vld, frm_cnt, frm_done, to_err, busy
  );
endinterface

// File: rtl/chip_sched.sv
// chip_sched
//   Frame scheduler for the chip path. Shares one chip output channel among
//   eight sensor-module channels with round-robin arbitration. A granted
//   frame waits for the chip buffer to report ready, then exactly len_q
//   sample strobes are gated through, followed by a one-cycle done pulse.
//
//   Ports:
//     clk_sys   system clock (only clock)
//     rst_n     asynchronous active-low reset
//     pluse_us  one-cycle pulse every microsecond (timeout time base)
//     bus       chip_sched_if.slave: requests/config/strobes in,
//               grant/sel_path/frm_vld/frm_cnt/frm_done/to_err/busy out
//
//   Parameters:
//     NCH    number of requesting channels (fixed at 8)
//     TO_US  ready-wait timeout in pluse_us ticks
//
//   Build option:
//     CHIP_SCHED_TIMEOUT_EN  when defined, a grant stuck waiting for buf_rdy
//                            is abandoned after TO_US ticks with a to_err
//                            pulse. When undefined the wait is unbounded and
//                            to_err is tied low.
module chip_sched #(
  parameter int NCH   = 8,
  parameter int TO_US = 1000
) (
  input  logic         clk_sys,
  input  logic         rst_n,
  input  logic         pluse_us,
  chip_sched_if.slave  bus
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_RDY = 2'd1;
  localparam logic [1:0] ST_XFER     = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

  logic [1:0]  state;
  logic [2:0]  ptr;
  logic [2:0]  ch;
  logic [3:0]  seq;
  logic [7:0]  grant;
  logic [19:0] len_q;
  logic [19:0] frm_cnt;
  logic        frm_vld;
  logic        frm_done;
  logic        busy;

  logic [7:0]  eff;
  logic        pick_ok;
  logic [2:0]  pick_idx;
  logic        tmo_hit;

  // Round-robin pick: first enabled request at or above ptr, wrapping.
  // The 3-bit index sum wraps naturally from 7 back to 0.
  always_comb begin
    eff      = bus.req & bus.cfg_mask;
    pick_ok  = 1'b0;
    pick_idx = ptr;
    for (int i = 0; i < NCH; i++) begin
      if (!pick_ok && eff[ptr + 3'(i)]) begin
        pick_ok  = 1'b1;
        pick_idx = ptr + 3'(i);
      end
    end
  end

  // Main frame FSM. Everything needed by the active frame (channel, length)
  // is latched at grant time so later request/config changes cannot disturb it.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      ch       <= '0;
      seq      <= '0;
      grant    <= '0;
      len_q    <= '0;
      frm_cnt  <= '0;
      frm_vld  <= 1'b0;
      frm_done <= 1'b0;
      busy     <= 1'b0;
    end else begin
      frm_vld  <= 1'b0;
      frm_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_ok && (bus.cfg_len != '0)) begin
            ch      <= pick_idx;
            grant   <= 8'b0000_0001 << pick_idx;
            len_q   <= bus.cfg_len;
            frm_cnt <= '0;
            busy    <= 1'b1;
            state   <= ST_WAIT_RDY;
          end
        end
        ST_WAIT_RDY: begin
          // Ready wins over a coincident timeout.
          if (bus.buf_rdy) begin
            state <= ST_XFER;
          end else if (tmo_hit) begin
            grant <= '0;
            ptr   <= ch + 3'd1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_XFER: begin
          // buf_rdy is deliberately ignored here: a started frame completes.
          if (bus.sm_vld) begin
            frm_vld <= 1'b1;
            frm_cnt <= frm_cnt + 20'd1;
            if ((frm_cnt + 20'd1) == len_q) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          frm_done <= 1'b1;
          ptr      <= ch + 3'd1;
          seq      <= seq + 4'd1;
          grant    <= '0;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef CHIP_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TO_US + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_US - 1);

  logic [TW-1:0] tmo_cnt;
  logic          to_err_q;

  // The tick that would bring the count to TO_US is the timeout event.
  assign tmo_hit = (state == ST_WAIT_RDY) && pluse_us && (tmo_cnt == TO_LAST);

  // Tick counter lives only in WAIT_RDY; it sits at zero everywhere else,
  // which makes it start from zero on every entry.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt  <= '0;
      to_err_q <= 1'b0;
    end else begin
      to_err_q <= tmo_hit && !bus.buf_rdy;
      if ((state != ST_WAIT_RDY) || tmo_hit) begin
        tmo_cnt <= '0;
      end else if (pluse_us) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
    end
  end

  assign bus.to_err = to_err_q;
`else
  localparam int unused_to_us = TO_US;
  logic unused_pluse;

  assign unused_pluse = pluse_us;
  assign tmo_hit      = 1'b0;
  assign bus.to_err   = 1'b0;
`endif

  assign bus.grant    = grant;
  assign bus.sel_path = {seq, ch};
  assign bus.frm_vld  = frm_vld;
  assign bus.frm_cnt  = frm_cnt;
  assign bus.frm_done = frm_done;
  assign bus.busy     = busy;

endmodule

// File: tb/tb_chip_sched.sv
// tb_chip_sched
//   Directed testbench for chip_sched. Inputs are driven and outputs are
//   sampled on the falling edge of clk_sys; a posedge monitor counts frm_vld,
//   frm_done and to_err pulses and records the order of new grants.
//   The DUT is built with TO_US=5 so the timeout path is short when
//   CHIP_SCHED_TIMEOUT_EN is defined.
module tb_chip_sched;

  logic clk_sys;
  logic rst_n;
  logic pluse_us;

  chip_sched_if sif ();

  chip_sched #(
    .NCH   (8),
    .TO_US (5)
  ) dut (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .pluse_us (pluse_us),
    .bus      (sif)
  );

  int checks;
  int errors;
  int vld_cnt;
  int done_cnt;
  int to_cnt;
  logic [7:0] prev_grant;
  logic [7:0] gq [$];
  logic [2:0] cq [$];

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Monitor samples pre-edge values at each rising edge.
  always @(posedge clk_sys) begin
    if (sif.frm_vld)  vld_cnt++;
    if (sif.frm_done) done_cnt++;
    if (sif.to_err)   to_cnt++;
    if ((sif.grant != 8'h00) && (prev_grant == 8'h00)) begin
      gq.push_back(sif.grant);
      cq.push_back(sif.sel_path[2:0]);
    end
    prev_grant = sif.grant;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic reset_pulse();
    @(negedge clk_sys);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (!sif.busy) break;
      cyc(1);
    end
    checks++;
    if (sif.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_idle_wait: busy=%b required 0 within 200 cycles", tag, sif.busy);
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    pluse_us = 1'b0;
    sif.req = 8'h00; sif.cfg_mask = 8'h00; sif.cfg_len = 20'd0;
    sif.sm_vld = 1'b0; sif.buf_rdy = 1'b0;
    cyc(3);
    checks++; if (sif.grant !== 8'h00) begin errors++; $display("[TB] FAIL reset_grant: got %h required 00", sif.grant); end
    checks++; if (sif.sel_path !== 7'h00) begin errors++; $display("[TB] FAIL reset_sel_path: got %h required 00", sif.sel_path); end
    checks++; if (sif.frm_vld !== 1'b0) begin errors++; $display("[TB] FAIL reset_frm_vld: got %b required 0", sif.frm_vld); end
    checks++; if (sif.frm_cnt !== 20'd0) begin errors++; $display("[TB] FAIL reset_frm_cnt: got %0d required 0", sif.frm_cnt); end
    checks++; if (sif.frm_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_frm_done: got %b required 0", sif.frm_done); end
    checks++; if (sif.to_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_to_err: got %b required 0", sif.to_err); end
    checks++; if (sif.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b required 0", sif.busy); end
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic test_basic_frame();
    sif.cfg_mask = 8'hFF; sif.cfg_len = 20'd10; sif.buf_rdy = 1'b1;
    sif.req = 8'h04;
    vld_cnt = 0; done_cnt = 0;
    cyc(1);
    checks++; if (sif.grant !== 8'h04) begin errors++; $display("[TB] FAIL basic_grant: got %h required 04", sif.grant); end
    checks++; if (sif.sel_path !== 7'h02) begin errors++; $display("[TB] FAIL basic_sel_path: got %h required 02", sif.sel_path); end
    checks++; if (sif.busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy: got %b required 1", sif.busy); end
    sif.req = 8'h00;
    sif.sm_vld = 1'b1;
    cyc(1);
    checks++; if (sif.frm_vld !== 1'b0) begin errors++; $display("[TB] FAIL basic_wait_not_counted: frm_vld=%b required 0", sif.frm_vld); end
    cyc(1);
    checks++; if (sif.frm_vld !== 1'b1) begin errors++; $display("[TB] FAIL basic_first_vld: frm_vld=%b required 1", sif.frm_vld); end
    checks++; if (sif.frm_cnt !== 20'd1) begin errors++; $display("[TB] FAIL basic_first_cnt: got %0d required 1", sif.frm_cnt); end
    cyc(9);
    checks++; if (sif.frm_cnt !== 20'd10) begin errors++; $display("[TB] FAIL basic_last_cnt: got %0d required 10", sif.frm_cnt); end
    checks++; if (sif.frm_done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_early: got %b required 0", sif.frm_done); end
    cyc(1);
    checks++; if (sif.frm_done !== 1'b1) begin errors++; $display("[TB] FAIL basic_done_pulse: got %b required 1", sif.frm_done); end
    checks++; if (sif.frm_vld !== 1'b0) begin errors++; $display("[TB] FAIL basic_extra_vld: frm_vld=%b required 0", sif.frm_vld); end
    checks++; if (sif.sel_path !== 7'h0A) begin errors++; $display("[TB] FAIL basic_seq: sel_path=%h required 0a", sif.sel_path); end
    checks++; if (sif.grant !== 8'h00) begin errors++; $display("[TB] FAIL basic_grant_clear: got %h required 00", sif.grant); end
    sif.sm_vld = 1'b0;
    cyc(3);
    checks++; if (vld_cnt !== 10) begin errors++; $display("[TB] FAIL basic_vld_count: got %0d required 10", vld_cnt); end
    checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL basic_done_count: got %0d required 1", done_cnt); end
    checks++; if (sif.frm_cnt !== 20'd10) begin errors++; $display("[TB] FAIL basic_cnt_hold: got %0d required 10", sif.frm_cnt); end
    checks++; if (sif.busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_end: got %b required 0", sif.busy); end
  endtask

  task automatic test_round_robin();
    reset_pulse();
    sif.cfg_mask = 8'hFF; sif.cfg_len = 20'd2; sif.buf_rdy = 1'b1;
    sif.sm_vld = 1'b1;
    gq.delete(); cq.delete();
    sif.req = 8'h81;
    for (int i = 0; i < 200 && gq.size() < 4; i++) cyc(1);
    sif.req = 8'h00;
    checks++;
    if (gq.size() < 4) begin
      errors++;
      $display("[TB] FAIL rr_grant_count: got %0d grants required 4", gq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        logic [7:0] eg;
        logic [2:0] ec;
        eg = (i % 2 == 0) ? 8'h01 : 8'h80;
        ec = (i % 2 == 0) ? 3'd0 : 3'd7;
        checks++; if (gq[i] !== eg) begin errors++; $display("[TB] FAIL rr_grant_%0d: got %h required %h", i, gq[i], eg); end
        checks++; if (cq[i] !== ec) begin errors++; $display("[TB] FAIL rr_ch_%0d: got %0d required %0d", i, cq[i], ec); end
      end
    end
    wait_idle("rr");
    sif.sm_vld = 1'b0;
    cyc(1);
  endtask

  task automatic test_mask_zero_len();
    sif.buf_rdy = 1'b1; sif.sm_vld = 1'b0;
    sif.req = 8'h02; sif.cfg_mask = 8'hFD; sif.cfg_len = 20'd3;
    cyc(5);
    checks++; if (sif.grant !== 8'h00) begin errors++; $display("[TB] FAIL mask_no_grant: got %h required 00", sif.grant); end
    checks++; if (sif.busy !== 1'b0) begin errors++; $display("[TB] FAIL mask_busy: got %b required 0", sif.busy); end
    sif.cfg_mask = 8'hFF; sif.cfg_len = 20'd0;
    cyc(5);
    checks++; if (sif.grant !== 8'h00) begin errors++; $display("[TB] FAIL zlen_no_grant: got %h required 00", sif.grant); end
    checks++; if (sif.busy !== 1'b0) begin errors++; $display("[TB] FAIL zlen_busy: got %b required 0", sif.busy); end
    sif.cfg_len = 20'd3;
    cyc(1);
    checks++; if (sif.grant !== 8'h02) begin errors++; $display("[TB] FAIL len3_grant: got %h required 02", sif.grant); end
    sif.req = 8'h00;
    vld_cnt = 0;
    sif.sm_vld = 1'b1;
    cyc(10);
    checks++; if (vld_cnt !== 3) begin errors++; $display("[TB] FAIL len3_vld_count: got %0d required 3", vld_cnt); end
    checks++; if (sif.frm_cnt !== 20'd3) begin errors++; $display("[TB] FAIL len3_frm_cnt: got %0d required 3", sif.frm_cnt); end
    sif.sm_vld = 1'b0;
    wait_idle("len3");
  endtask

  task automatic test_ready_stall();
    sif.buf_rdy = 1'b0; sif.sm_vld = 1'b0;
    sif.cfg_mask = 8'hFF; sif.cfg_len = 20'd4; sif.req = 8'h10;
    vld_cnt = 0; done_cnt = 0;
    cyc(1);
    checks++; if (sif.grant !== 8'h10) begin errors++; $display("[TB] FAIL stall_grant: got %h required 10", sif.grant); end
    sif.req = 8'h00;
    for (int i = 0; i < 50; i++) begin
      sif.sm_vld = ~sif.sm_vld;
      cyc(1);
    end
    checks++; if (vld_cnt !== 0) begin errors++; $display("[TB] FAIL stall_no_vld: got %0d required 0", vld_cnt); end
    checks++; if (sif.frm_cnt !== 20'd0) begin errors++; $display("[TB] FAIL stall_cnt: got %0d required 0", sif.frm_cnt); end
    checks++; if (sif.busy !== 1'b1) begin errors++; $display("[TB] FAIL stall_busy: got %b required 1", sif.busy); end
    sif.buf_rdy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sif.sm_vld = ~sif.sm_vld;
      cyc(1);
    end
    sif.buf_rdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sif.sm_vld = ~sif.sm_vld;
      cyc(1);
    end
    sif.sm_vld = 1'b0;
    cyc(2);
    checks++; if (vld_cnt !== 4) begin errors++; $display("[TB] FAIL stall_vld_count: got %0d required 4", vld_cnt); end
    checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL stall_done_count: got %0d required 1", done_cnt); end
    checks++; if (sif.frm_cnt !== 20'd4) begin errors++; $display("[TB] FAIL stall_frm_cnt: got %0d required 4", sif.frm_cnt); end
    checks++; if (sif.busy !== 1'b0) begin errors++; $display("[TB] FAIL stall_busy_end: got %b required 0", sif.busy); end
  endtask

  task automatic test_reset_mid_frame();
    sif.cfg_mask = 8'hFF; sif.cfg_len = 20'd10; sif.buf_rdy = 1'b1;
    sif.sm_vld = 1'b0; sif.req = 8'h04;
    done_cnt = 0;
    cyc(1);
    checks++; if (sif.grant !== 8'h04) begin errors++; $display("[TB] FAIL rmid_grant: got %h required 04", sif.grant); end
    sif.req = 8'h00;
    sif.sm_vld = 1'b1;
    cyc(5);
    checks++; if (sif.frm_cnt !== 20'd4) begin errors++; $display("[TB] FAIL rmid_cnt_before: got %0d required 4", sif.frm_cnt); end
    rst_n = 1'b0;
    #1;
    checks++; if (sif.grant !== 8'h00) begin errors++; $display("[TB] FAIL rmid_grant_clr: got %h required 00", sif.grant); end
    checks++; if (sif.sel_path !== 7'h00) begin errors++; $display("[TB] FAIL rmid_sel_clr: got %h required 00", sif.sel_path); end
    checks++; if (sif.frm_vld !== 1'b0) begin errors++; $display("[TB] FAIL rmid_vld_clr: got %b required 0", sif.frm_vld); end
    checks++; if (sif.frm_cnt !== 20'd0) begin errors++; $display("[TB] FAIL rmid_cnt_clr: got %0d required 0", sif.frm_cnt); end
    checks++; if (sif.busy !== 1'b0) begin errors++; $display("[TB] FAIL rmid_busy_clr: got %b required 0", sif.busy); end
    sif.sm_vld = 1'b0;
    sif.req = 8'h10;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    checks++; if (sif.grant !== 8'h10) begin errors++; $display("[TB] FAIL rmid_regrant: got %h required 10", sif.grant); end
    checks++; if (sif.sel_path !== 7'h04) begin errors++; $display("[TB] FAIL rmid_sel_path: got %h required 04", sif.sel_path); end
    sif.req = 8'h00;
    sif.sm_vld = 1'b1;
    cyc(16);
    checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL rmid_done_count: got %0d required 1", done_cnt); end
    sif.sm_vld = 1'b0;
    wait_idle("rmid");
  endtask

`ifdef CHIP_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    reset_pulse();
    sif.cfg_mask = 8'hFF; sif.cfg_len = 20'd4; sif.buf_rdy = 1'b0;
    sif.sm_vld = 1'b0; sif.req = 8'h03;
    to_cnt = 0; done_cnt = 0;
    cyc(1);
    checks++; if (sif.grant !== 8'h01) begin errors++; $display("[TB] FAIL to_first_grant: got %h required 01", sif.grant); end
    for (int i = 0; i < 4; i++) begin
      pluse_us = 1'b1; cyc(1);
      pluse_us = 1'b0; cyc(2);
    end
    checks++; if (to_cnt !== 0) begin errors++; $display("[TB] FAIL to_early: to_err pulses %0d required 0", to_cnt); end
    checks++; if (sif.grant !== 8'h01) begin errors++; $display("[TB] FAIL to_hold_grant: got %h required 01", sif.grant); end
    pluse_us = 1'b1; cyc(1);
    pluse_us = 1'b0;
    checks++; if (sif.to_err !== 1'b1) begin errors++; $display("[TB] FAIL to_pulse: got %b required 1", sif.to_err); end
    checks++; if (sif.grant !== 8'h00) begin errors++; $display("[TB] FAIL to_grant_clr: got %h required 00", sif.grant); end
    checks++; if (sif.busy !== 1'b0) begin errors++; $display("[TB] FAIL to_busy: got %b required 0", sif.busy); end
    cyc(1);
    checks++; if (sif.to_err !== 1'b0) begin errors++; $display("[TB] FAIL to_pulse_width: got %b required 0", sif.to_err); end
    checks++; if (sif.grant !== 8'h02) begin errors++; $display("[TB] FAIL to_next_grant: got %h required 02", sif.grant); end
    checks++; if (sif.sel_path !== 7'h01) begin errors++; $display("[TB] FAIL to_seq_kept: sel_path=%h required 01", sif.sel_path); end
    cyc(1);
    checks++; if (to_cnt !== 1) begin errors++; $display("[TB] FAIL to_count: got %0d required 1", to_cnt); end
    checks++; if (done_cnt !== 0) begin errors++; $display("[TB] FAIL to_no_done: got %0d required 0", done_cnt); end
    sif.req = 8'h00; sif.buf_rdy = 1'b1; sif.sm_vld = 1'b1;
    wait_idle("to");
    sif.sm_vld = 1'b0;
  endtask
`else
  task automatic test_no_timeout();
    reset_pulse();
    sif.cfg_mask = 8'hFF; sif.cfg_len = 20'd4; sif.buf_rdy = 1'b0;
    sif.sm_vld = 1'b0; sif.req = 8'h01;
    to_cnt = 0;
    cyc(1);
    sif.req = 8'h00;
    for (int i = 0; i < 10; i++) begin
      pluse_us = 1'b1; cyc(1);
      pluse_us = 1'b0; cyc(1);
    end
    checks++; if (to_cnt !== 0) begin errors++; $display("[TB] FAIL noto_pulses: got %0d required 0", to_cnt); end
    checks++; if (sif.grant !== 8'h01) begin errors++; $display("[TB] FAIL noto_grant: got %h required 01", sif.grant); end
    checks++; if (sif.busy !== 1'b1) begin errors++; $display("[TB] FAIL noto_busy: got %b required 1", sif.busy); end
    sif.buf_rdy = 1'b1; sif.sm_vld = 1'b1;
    wait_idle("noto");
    sif.sm_vld = 1'b0;
  endtask
`endif

  initial begin
    checks = 0; errors = 0;
    vld_cnt = 0; done_cnt = 0; to_cnt = 0;
    prev_grant = 8'h00;
    $display("[TB] chip_sched directed test start");
    test_reset();
    test_basic_frame();
    test_round_robin();
    test_mask_zero_len();
    test_ready_stall();
    test_reset_mid_frame();
`ifdef CHIP_SCHED_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
